// File: rtl/pfd_lockdet.sv
// pfd_lockdet: oversampled phase-frequency detector with overlap pulse,
// signed phase error, cycle-slip flag and optional lock detector (PFD_LOCK_DET_EN).
module pfd_lockdet #(
    parameter int CNT_W      = 8,
    parameter int MIN_PULSE  = 2,
    parameter int LOCK_TOL   = 2,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               ref_in,
    input  logic               fb_in,
    output logic               up,
    output logic               down,
    output logic signed [CNT_W:0] phase_err,
    output logic               err_valid,
    output logic               cycle_slip,
    output logic               locked
);

    localparam int OVL_W = $clog2(MIN_PULSE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DN, S_OVL} state_t;

    logic r_ref_s1, r_ref_s2, r_ref_d;
    logic r_fb_s1, r_fb_s2, r_fb_d;
    state_t r_state, w_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [OVL_W-1:0] r_ovl, w_ovl_nxt;
    logic r_pend_ref, r_pend_fb, w_pr_nxt, w_pf_nxt;
    logic r_up, r_down, r_err_v, r_slip;
    logic signed [CNT_W:0] r_err, w_err, w_mag;
    logic w_err_v, w_slip, w_up, w_down;
    logic w_ref_e, w_fb_e, w_open_r, w_open_f;

    assign w_ref_e   = r_ref_s2 & ~r_ref_d;
    assign w_fb_e    = r_fb_s2 & ~r_fb_d;
    assign w_mag     = $signed({1'b0, r_cnt});
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // Two-flop synchronisers plus delay flop for rising-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_s1 <= 1'b0;
            r_ref_s2 <= 1'b0;
            r_ref_d  <= 1'b0;
            r_fb_s1  <= 1'b0;
            r_fb_s2  <= 1'b0;
            r_fb_d   <= 1'b0;
        end else begin
            r_ref_s1 <= ref_in;
            r_ref_s2 <= r_ref_s1;
            r_ref_d  <= r_ref_s2;
            r_fb_s1  <= fb_in;
            r_fb_s2  <= r_fb_s1;
            r_fb_d   <= r_fb_s2;
        end
    end

    // State register with pulse/overlap counters and pending edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ovl      <= '0;
            r_pend_ref <= 1'b0;
            r_pend_fb  <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovl      <= w_ovl_nxt;
            r_pend_ref <= w_pr_nxt;
            r_pend_fb  <= w_pf_nxt;
        end
    end

    // Next-state logic; an OVL exit reuses the IDLE opening decision
    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_ovl_nxt = r_ovl;
        w_pr_nxt  = r_pend_ref;
        w_pf_nxt  = r_pend_fb;
        w_err     = r_err;
        w_err_v   = 1'b0;
        w_slip    = 1'b0;
        w_open_r  = 1'b0;
        w_open_f  = 1'b0;
        if (!en) begin
            w_nxt    = S_IDLE;
            w_pr_nxt = 1'b0;
            w_pf_nxt = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_open_r = w_ref_e;
                    w_open_f = w_fb_e;
                end
                S_UP: begin
                    w_cnt_nxt = w_cnt_inc;
                    w_slip    = w_ref_e;
                    if (w_fb_e) begin
                        w_nxt   = S_IDLE;
                        w_err   = w_mag;
                        w_err_v = 1'b1;
                    end
                end
                S_DN: begin
                    w_cnt_nxt = w_cnt_inc;
                    w_slip    = w_fb_e;
                    if (w_ref_e) begin
                        w_nxt   = S_IDLE;
                        w_err   = -w_mag;
                        w_err_v = 1'b1;
                    end
                end
                S_OVL: begin
                    if (r_ovl == OVL_W'(1)) begin
                        w_nxt    = S_IDLE;
                        w_open_r = r_pend_ref | w_ref_e;
                        w_open_f = r_pend_fb | w_fb_e;
                        w_pr_nxt = 1'b0;
                        w_pf_nxt = 1'b0;
                    end else begin
                        w_ovl_nxt = r_ovl - OVL_W'(1);
                        w_pr_nxt  = r_pend_ref | w_ref_e;
                        w_pf_nxt  = r_pend_fb | w_fb_e;
                    end
                end
            endcase
            if (w_open_r && w_open_f) begin
                w_nxt     = S_OVL;
                w_ovl_nxt = OVL_W'(MIN_PULSE);
                w_err     = '0;
                w_err_v   = 1'b1;
            end else if (w_open_r) begin
                w_nxt     = S_UP;
                w_cnt_nxt = CNT_W'(1);
            end else if (w_open_f) begin
                w_nxt     = S_DN;
                w_cnt_nxt = CNT_W'(1);
            end
        end
    end

    // Output decode of the upcoming state
    always_comb begin
        w_up   = (w_nxt == S_UP) || (w_nxt == S_OVL);
        w_down = (w_nxt == S_DN) || (w_nxt == S_OVL);
    end

    // Registered outputs so up/down change with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_err   <= '0;
            r_err_v <= 1'b0;
            r_slip  <= 1'b0;
        end else begin
            r_up    <= w_up;
            r_down  <= w_down;
            r_err   <= w_err;
            r_err_v <= w_err_v;
            r_slip  <= w_slip;
        end
    end

    assign up         = r_up;
    assign down       = r_down;
    assign phase_err  = r_err;
    assign err_valid  = r_err_v;
    assign cycle_slip = r_slip;

`ifdef PFD_LOCK_DET_EN
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    logic [GW-1:0] r_good;
    logic [BW-1:0] r_bad;
    logic r_locked;
    logic [CNT_W:0] w_abs;
    logic w_in_tol;

    assign w_abs    = w_err[CNT_W] ? $unsigned(-w_err) : $unsigned(w_err);
    assign w_in_tol = w_abs <= (CNT_W + 1)'(LOCK_TOL);

    // Lock detector, updated alongside the err_valid/cycle_slip strobes
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_good   <= '0;
            r_bad    <= '0;
            r_locked <= 1'b0;
        end else begin
            if (w_err_v) begin
                if (w_in_tol) begin
                    r_bad <= '0;
                    if (r_good != GW'(LOCK_CNT))
                        r_good <= r_good + GW'(1);
                    if (r_good >= GW'(LOCK_CNT - 1))
                        r_locked <= 1'b1;
                end else begin
                    r_good <= '0;
                    if (r_bad != BW'(UNLOCK_CNT))
                        r_bad <= r_bad + BW'(1);
                    if (r_bad >= BW'(UNLOCK_CNT - 1))
                        r_locked <= 1'b0;
                end
            end
            if (w_slip) begin
                r_locked <= 1'b0;
                r_good   <= '0;
            end
        end
    end

    assign locked = r_locked;
`else
    logic w_lock_unused;
    assign w_lock_unused = (LOCK_TOL + LOCK_CNT + UNLOCK_CNT) != 0;
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_lockdet.sv
// tb_pfd_lockdet: directed stimulus with scoreboard queues checked by a
// monitor on err_valid / cycle_slip, plus up/down pulse-width checks.
module tb_pfd_lockdet;

`ifdef PFD_LOCK_DET_EN
    localparam bit LKEN = 1'b1;
`else
    localparam bit LKEN = 1'b0;
`endif

    typedef struct {
        int err;
        bit lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en, ref_in, fb_in, ref2, fb2;
    logic up, down, err_valid, cycle_slip, locked;
    logic signed [8:0] phase_err;
    logic up2, down2, err_valid2, cycle_slip2, locked2;
    logic signed [2:0] phase_err2;

    int total = 0;
    int bad = 0;
    int n_up = 0, n_dn = 0, n_ov = 0;
    int n_up2 = 0, n_dn2 = 0, n_ov2 = 0;
    int s_up, s_dn, s_ov;

    exp_t q_err[$];
    bit   q_slip[$];
    int   q2[$];

    always #5 clk = ~clk;

    pfd_lockdet dut (
        .clk(clk), .rst(rst), .en(en),
        .ref_in(ref_in), .fb_in(fb_in),
        .up(up), .down(down), .phase_err(phase_err),
        .err_valid(err_valid), .cycle_slip(cycle_slip),
        .locked(locked)
    );

    pfd_lockdet #(.CNT_W(2), .MIN_PULSE(3)) u2 (
        .clk(clk), .rst(rst), .en(en),
        .ref_in(ref2), .fb_in(fb2),
        .up(up2), .down(down2), .phase_err(phase_err2),
        .err_valid(err_valid2), .cycle_slip(cycle_slip2),
        .locked(locked2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // pulse-width counters
    always @(negedge clk) begin
        if (up) n_up++;
        if (down) n_dn++;
        if (up && down) n_ov++;
        if (up2) n_up2++;
        if (down2) n_dn2++;
        if (up2 && down2) n_ov2++;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (err_valid) begin
            if (q_err.size() == 0) begin
                chk("spurious_err_valid", int'(err_valid), 0);
            end else begin
                e = q_err.pop_front();
                chk("phase_err", phase_err, e.err);
                chk("locked_at_err", int'(locked), int'(e.lk));
            end
        end
        if (cycle_slip) begin
            if (q_slip.size() == 0) begin
                chk("spurious_slip", int'(cycle_slip), 0);
            end else begin
                chk("locked_at_slip", int'(locked), int'(q_slip.pop_front()));
            end
        end
        if (err_valid2) begin
            if (q2.size() == 0)
                chk("spurious_err_valid2", int'(err_valid2), 0);
            else
                chk("phase_err2", phase_err2, q2.pop_front());
        end
        if (cycle_slip2)
            chk("spurious_slip2", int'(cycle_slip2), 0);
    end

    task automatic run(input bit sel, input int r0, input int r1,
                       input int f0, input int f1, input int len);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (sel) begin
                ref2 = (c == r0) || (c == r1);
                fb2  = (c == f0) || (c == f1);
            end else begin
                ref_in = (c == r0) || (c == r1);
                fb_in  = (c == f0) || (c == f1);
            end
        end
        @(negedge clk);
        ref_in = 1'b0; fb_in = 1'b0; ref2 = 1'b0; fb2 = 1'b0;
    endtask

    task automatic snap(input bit sel);
        s_up = sel ? n_up2 : n_up;
        s_dn = sel ? n_dn2 : n_dn;
        s_ov = sel ? n_ov2 : n_ov;
    endtask

    task automatic wchk(input string nm, input bit sel,
                        input int eu, input int ed, input int eo);
        chk({nm, "_up_cycles"}, (sel ? n_up2 : n_up) - s_up, eu);
        chk({nm, "_dn_cycles"}, (sel ? n_dn2 : n_dn) - s_dn, ed);
        chk({nm, "_ovl_cycles"}, (sel ? n_ov2 : n_ov) - s_ov, eo);
    endtask

    task automatic push(input int err, input bit lk);
        exp_t e;
        e.err = err;
        e.lk  = lk;
        q_err.push_back(e);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        ref_in = 1'b0; fb_in = 1'b0; ref2 = 1'b0; fb2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_up", int'(up), 0);
        chk("rst_down", int'(down), 0);
        chk("rst_phase_err", phase_err, 0);
        chk("rst_err_valid", int'(err_valid), 0);
        chk("rst_cycle_slip", int'(cycle_slip), 0);
        chk("rst_locked", int'(locked), 0);

        // coincident edges: overlap of MIN_PULSE, zero error
        push(0, 1'b0);
        snap(1'b0);
        run(1'b0, 0, -1, 0, -1, 8);
        wchk("coinc", 1'b0, 2, 2, 2);

        // ref leads by 3
        push(3, 1'b0);
        snap(1'b0);
        run(1'b0, 0, -1, 3, -1, 10);
        wchk("ref_lead3", 1'b0, 3, 0, 0);

        // fb leads by 5
        push(-5, 1'b0);
        snap(1'b0);
        run(1'b0, 5, -1, 0, -1, 12);
        wchk("fb_lead5", 1'b0, 0, 5, 0);

        // CNT_W=2 saturates at 3
        q2.push_back(-3);
        snap(1'b1);
        run(1'b1, 10, -1, 0, -1, 16);
        wchk("sat", 1'b1, 0, 10, 0);

        // ref edge during a 3-cycle overlap opens UP on exit
        q2.push_back(0);
        q2.push_back(2);
        snap(1'b1);
        run(1'b1, 0, 2, 0, 5, 12);
        wchk("pend", 1'b1, 5, 3, 3);

        // 16 in-tolerance comparisons
        for (int i = 0; i < 16; i++) begin
            push(1, LKEN && (i == 15));
            run(1'b0, 0, -1, 1, -1, 6);
        end
        // four out-of-tolerance comparisons
        for (int i = 0; i < 4; i++) begin
            push(7, LKEN && (i < 3));
            run(1'b0, 0, -1, 7, -1, 12);
        end
        // relock with -2 errors
        for (int i = 0; i < 16; i++) begin
            push(-2, LKEN && (i == 15));
            run(1'b0, 2, -1, 0, -1, 7);
        end

        // two ref edges before fb: slip drops lock, UP keeps running
        q_slip.push_back(1'b0);
        push(6, 1'b0);
        snap(1'b0);
        run(1'b0, 0, 3, 6, -1, 12);
        wchk("slip", 1'b0, 6, 0, 0);

        // rst mid-UP
        @(negedge clk); ref_in = 1'b1;
        @(negedge clk); ref_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_up", int'(up), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_up", int'(up), 0);
        chk("rst_mid_phase_err", phase_err, 0);
        chk("rst_mid_locked", int'(locked), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_up", int'(up), 0);

        // en=0 mid-UP
        @(negedge clk); ref_in = 1'b1;
        @(negedge clk); ref_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_en_up", int'(up), 1);
        en = 1'b0;
        @(negedge clk);
        chk("en0_up", int'(up), 0);
        chk("en0_down", int'(down), 0);
        chk("en0_locked", int'(locked), 0);
        en = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_en_up", int'(up), 0);

        // recovery after re-enable
        push(2, 1'b0);
        snap(1'b0);
        run(1'b0, 0, -1, 2, -1, 8);
        wchk("recover", 1'b0, 2, 0, 0);

        repeat (6) @(negedge clk);
        chk("q_err_drained", q_err.size(), 0);
        chk("q_slip_drained", q_slip.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
